// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage: access FSM states and
// the doubleword alignment constant.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Addresses are doubleword aligned: the low OFFSET_BITS bits are dropped.
    localparam int OFFSET_BITS = 3;

endpackage

// File: rtl/access_timer.sv
// Up-counter for the WAIT phase; expired is raised once the count reaches
// TIMEOUT-1, which is the last WAIT cycle an ack is still waited for.
module access_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/memory_access.sv
// Pipeline memory stage: issues one data-memory access per load/store,
// stalls upstream until ack or timeout, and resolves the branch select.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access in flight; a load/store launches one
// WAIT    | request on the bus, waiting for dm_ack or timeout
// DONE    | completion cycle; stall released, nothing new starts
module memory_access
    import mem_pkg::*;
#(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         MemRead_M,
    input  logic         MemWrite_M,
    input  logic         Branch_M,
    input  logic         zero_M,
    input  logic [N-1:0] aluResult_M,
    input  logic [N-1:0] writeData_M,
    output logic         PCSrc_M,
    output logic [N-1:0] readData_M,
    output logic         stall_M,
    output logic         err_M,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic         dm_ack,
    input  logic [N-1:0] dm_rdata
);

    localparam logic [N-1:0] ALIGN_MASK = ~((N'(1) << OFFSET_BITS) - N'(1));

    state_t state;
    logic   mem_op;
    logic   timer_clear;
    logic   timer_en;
    logic   timer_expired;

    assign mem_op  = MemRead_M | MemWrite_M;
    assign PCSrc_M = Branch_M & zero_M;
    assign dm_req  = (state == ST_WAIT);
    assign stall_M = ((state == ST_IDLE) & mem_op) | dm_req;

    // Timer only runs inside WAIT and restarts from zero on every entry.
    assign timer_en    = (state == ST_WAIT);
    assign timer_clear = (state != ST_WAIT) | dm_ack;

    access_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .expired(timer_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            dm_we      <= 1'b0;
            dm_addr    <= '0;
            dm_wdata   <= '0;
            readData_M <= '0;
            err_M      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        dm_addr  <= aluResult_M & ALIGN_MASK;
                        dm_wdata <= writeData_M;
                        dm_we    <= MemWrite_M;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // An ack arriving on the timeout cycle still completes normally.
                    if (dm_ack) begin
                        if (!dm_we) begin
                            readData_M <= dm_rdata;
                        end
                        state <= ST_DONE;
                    end else if (timer_expired) begin
                        readData_M <= '0;
                        err_M      <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: transaction-level reference model checked
// every cycle, plus literal expectations for the key access scenarios.
module tb_memory_access;

    localparam int N  = 64;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         MemRead_M, MemWrite_M, Branch_M, zero_M;
    logic [N-1:0] aluResult_M, writeData_M;
    logic         PCSrc_M;
    logic [N-1:0] readData_M;
    logic         stall_M, err_M;
    logic         dm_req, dm_we;
    logic [N-1:0] dm_addr, dm_wdata;
    logic         dm_ack;
    logic [N-1:0] dm_rdata;

    int tests = 0;
    int fails = 0;

    memory_access #(.N(N), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead_M  (MemRead_M),
        .MemWrite_M (MemWrite_M),
        .Branch_M   (Branch_M),
        .zero_M     (zero_M),
        .aluResult_M(aluResult_M),
        .writeData_M(writeData_M),
        .PCSrc_M    (PCSrc_M),
        .readData_M (readData_M),
        .stall_M    (stall_M),
        .err_M      (err_M),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_ack     (dm_ack),
        .dm_rdata   (dm_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one access in flight, counted in elapsed wait cycles.
    logic         m_busy, m_finish, m_we, m_err;
    int           m_waits;
    logic [N-1:0] m_addr, m_wdata, m_rdata;

    function automatic void model_reset();
        m_busy   = 1'b0;
        m_finish = 1'b0;
        m_waits  = 0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_rdata  = '0;
        m_err    = 1'b0;
    endfunction

    always @(negedge clk) begin
        if (!reset) model_reset();
        chkb("pcsrc", PCSrc_M, Branch_M & zero_M);
        chkb("stall", stall_M, m_busy | (!m_finish & (MemRead_M | MemWrite_M)));
        chkb("dm_req", dm_req, m_busy);
        chkb("dm_we", dm_we, m_we);
        chk("dm_addr", dm_addr, m_addr);
        chk("dm_wdata", dm_wdata, m_wdata);
        chk("read_data", readData_M, m_rdata);
        chkb("err", err_M, m_err);
    end

    always @(posedge clk) begin
        if (!reset) begin
            model_reset();
        end else if (m_finish) begin
            m_finish = 1'b0;
        end else if (m_busy) begin
            if (dm_ack) begin
                if (!m_we) m_rdata = dm_rdata;
                m_busy   = 1'b0;
                m_finish = 1'b1;
            end else if (m_waits + 1 == TO) begin
                m_rdata  = '0;
                m_err    = 1'b1;
                m_busy   = 1'b0;
                m_finish = 1'b1;
            end else begin
                m_waits++;
            end
        end else if (MemRead_M || MemWrite_M) begin
            m_busy  = 1'b1;
            m_waits = 0;
            m_we    = MemWrite_M;
            m_addr  = {aluResult_M[N-1:3], 3'b000};
            m_wdata = writeData_M;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one access; ack_at is the 1-based WAIT cycle carrying dm_ack (0 = never).
    task automatic do_access(input logic rd, input logic wr, input logic [N-1:0] addr,
                             input logic [N-1:0] wd, input logic [N-1:0] rdv, input int ack_at,
                             output int stalls, output logic [N-1:0] first_addr,
                             output logic [N-1:0] first_wdata, output logic first_we,
                             output logic [N-1:0] done_rdata, output logic done_err);
        logic done;
        done        = 1'b0;
        stalls      = 0;
        first_addr  = '0;
        first_wdata = '0;
        first_we    = 1'b0;
        done_rdata  = '0;
        done_err    = 1'b0;
        MemRead_M   = rd;
        MemWrite_M  = wr;
        aluResult_M = addr;
        writeData_M = wd;
        for (int c = 0; c < TO + 4 && !done; c++) begin
            Branch_M = 1'($urandom);
            zero_M   = 1'($urandom);
            dm_ack   = (ack_at != 0 && c == ack_at);
            dm_rdata = dm_ack ? rdv : N'({$urandom, $urandom});
            @(negedge clk);
            if (c == 1) begin
                first_addr  = dm_addr;
                first_wdata = dm_wdata;
                first_we    = dm_we;
            end
            if (stall_M) begin
                stalls++;
            end else begin
                done       = 1'b1;
                done_rdata = readData_M;
                done_err   = err_M;
            end
            step();
        end
        dm_ack     = 1'b0;
        MemRead_M  = 1'b0;
        MemWrite_M = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL access_bound: no completion after %0d cycles, required completion", TO + 4);
        end
    endtask

    initial begin
        int           st;
        logic [N-1:0] fa, fw, rd_v;
        logic         fwe, er;

        model_reset();
        reset       = 1'b0;
        MemRead_M   = 1'b0;
        MemWrite_M  = 1'b0;
        Branch_M    = 1'b0;
        zero_M      = 1'b0;
        aluResult_M = '0;
        writeData_M = '0;
        dm_ack      = 1'b0;
        dm_rdata    = '0;

        @(negedge clk);
        chk("rst_read_data", readData_M, 64'h0);
        chkb("rst_err", err_M, 1'b0);
        chkb("rst_dm_req", dm_req, 1'b0);
        chk("rst_dm_addr", dm_addr, 64'h0);
        step();
        reset = 1'b1;
        step();

        // Load, ack on first WAIT cycle.
        do_access(1'b1, 1'b0, 64'h1005, 64'h0, 64'hDEADBEEF, 1, st, fa, fw, fwe, rd_v, er);
        chki("load_stalls", st, 2);
        chk("load_addr", fa, 64'h1000);
        chkb("load_we", fwe, 1'b0);
        chk("load_data", rd_v, 64'hDEADBEEF);

        // Store, ack on third WAIT cycle.
        do_access(1'b0, 1'b1, 64'h20, 64'h55, 64'hBAD, 3, st, fa, fw, fwe, rd_v, er);
        chki("store_stalls", st, 4);
        chkb("store_we", fwe, 1'b1);
        chk("store_wdata", fw, 64'h55);
        chk("store_keeps_data", rd_v, 64'hDEADBEEF);

        // Read and write together resolves as a write.
        do_access(1'b1, 1'b1, 64'h4F, 64'h7, 64'h999, 1, st, fa, fw, fwe, rd_v, er);
        chkb("both_we", fwe, 1'b1);
        chk("both_wdata", fw, 64'h7);
        chk("both_addr", fa, 64'h48);
        chk("both_keeps_data", rd_v, 64'hDEADBEEF);

        // Branch with no memory op: PCSrc follows zero, never stalls.
        Branch_M = 1'b1;
        for (int i = 0; i < 6; i++) begin
            zero_M = i[0];
            @(negedge clk);
            chkb("branch_pcsrc", PCSrc_M, i[0]);
            chkb("branch_stall", stall_M, 1'b0);
            step();
        end
        Branch_M = 1'b0;

        // Stray ack while idle is ignored.
        dm_ack   = 1'b1;
        dm_rdata = 64'hFFFF;
        step();
        dm_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack", readData_M, 64'hDEADBEEF);
        step();

        // Load with no ack times out after TO WAIT cycles.
        do_access(1'b1, 1'b0, 64'h300, 64'h0, 64'h0, 0, st, fa, fw, fwe, rd_v, er);
        chki("timeout_stalls", st, TO + 1);
        chk("timeout_data", rd_v, 64'h0);
        chkb("timeout_err", er, 1'b1);

        // Ack on the timeout cycle wins; err stays sticky from before.
        do_access(1'b1, 1'b0, 64'h308, 64'h0, 64'h1234, TO, st, fa, fw, fwe, rd_v, er);
        chki("late_ack_stalls", st, TO + 1);
        chk("late_ack_data", rd_v, 64'h1234);
        chkb("err_sticky", er, 1'b1);

        // Reset during the second WAIT cycle, then a stray ack.
        MemRead_M   = 1'b1;
        aluResult_M = 64'h400;
        step();
        step();
        reset = 1'b0;
        #1;
        chkb("mid_rst_dm_req", dm_req, 1'b0);
        chk("mid_rst_data", readData_M, 64'h0);
        chkb("mid_rst_err", err_M, 1'b0);
        MemRead_M = 1'b0;
        step();
        reset    = 1'b1;
        dm_ack   = 1'b1;
        dm_rdata = 64'hABC;
        @(negedge clk);
        chkb("post_rst_req", dm_req, 1'b0);
        step();
        dm_ack = 1'b0;
        @(negedge clk);
        chk("post_rst_ack_ignored", readData_M, 64'h0);
        chkb("post_rst_stall", stall_M, 1'b0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter N, default 64: datapath width in bits.
REQ-002 Parameter TIMEOUT, default 16: maximum WAIT cycles before an access is abandoned.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 MemRead_M  input  1  current instruction is a load.
REQ-006 MemWrite_M  input  1  current instruction is a store.
REQ-007 Branch_M  input  1  current instruction is a conditional branch.
REQ-008 zero_M  input  1  ALU zero flag from execute.
REQ-009 aluResult_M  input  N  effective address from execute.
REQ-010 writeData_M  input  N  store data from execute.
REQ-011 PCSrc_M  output  1  branch-taken select for PC mux.
REQ-012 readData_M  output  N  load data to writeback.
REQ-013 stall_M  output  1  freezes PC and upstream while high.
REQ-014 err_M  output  1  sticky timeout flag.
REQ-015 dm_req  output  1  data-memory request.
REQ-016 dm_we  output  1  1 = write, 0 = read.
REQ-017 dm_addr  output  N  doubleword address, bits [2:0] forced to 0.
REQ-018 dm_wdata  output  N  write data.
REQ-019 dm_ack  input  1  memory completion strobe, one cycle.
REQ-020 dm_rdata  input  N  read data, valid with dm_ack.

Function
REQ-021 PCSrc_M SHALL equal Branch_M & zero_M, combinational, independent of state.
REQ-022 FSM states SHALL be IDLE, WAIT, DONE.
REQ-023 IDLE: if MemRead_M|MemWrite_M, go to WAIT and register the address as {aluResult_M[N-1:3],3'b0}, the write data as writeData_M, and the write enable as MemWrite_M.
REQ-024 If MemRead_M and MemWrite_M are both high, the access SHALL be a write.
REQ-025 WAIT: dm_req=1 and dm_addr/dm_wdata/dm_we SHALL be held stable from the registered values.
REQ-026 WAIT with dm_ack=1: capture dm_rdata into readData_M if read (hold readData_M if write), clear the timer, go to DONE.
REQ-027 WAIT: the timer SHALL increment each cycle without ack. When it reaches TIMEOUT-1 without ack, set readData_M=0, set err_M, and go to DONE.
REQ-028 An ack in the same cycle as the timeout SHALL win: normal completion, err_M unchanged.
REQ-029 DONE: stall_M=0, dm_req=0, no new access starts, go to IDLE unconditionally.
REQ-030 stall_M = (IDLE & (MemRead_M|MemWrite_M)) | WAIT, combinational.
REQ-031 Minimum access: 2 stall cycles (IDLE, WAIT with ack), completion in the third cycle (DONE).
REQ-032 dm_ack outside WAIT SHALL be ignored.
REQ-033 Non-memory instructions SHALL pass with zero stall; readData_M SHALL hold its last value.
REQ-034 Once set, err_M SHALL stay high until reset.

Reset
REQ-035 Reset asserted SHALL immediately force: state IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, readData_M=0, err_M=0, timer=0.
REQ-036 Reset during WAIT SHALL abandon the access; a later dm_ack SHALL be ignored.

Structure
REQ-037 The state enum SHALL live in the shared package mem_pkg.
REQ-038 The WAIT counter SHALL be sub-module access_timer: inputs clear and enable, output expired, parameter TIMEOUT.
REQ-039 The timer width SHALL be $clog2(TIMEOUT).

Verification
REQ-040 Load at aluResult_M=0x1005, ack on the first WAIT cycle with dm_rdata=0xDEADBEEF -> dm_addr=0x1000, dm_we=0, stall high 2 cycles, readData_M=0xDEADBEEF in DONE.
REQ-041 Store writeData_M=0x55 at address 0x20, ack after 3 WAIT cycles -> dm_we=1, dm_wdata=0x55 stable, stall high 4 cycles, readData_M unchanged.
REQ-042 Load with no ack, TIMEOUT=16 -> DONE after 16 WAIT cycles, readData_M=0, err_M=1 and still 1 after the next successful access.
REQ-043 Branch_M=1 with zero_M toggling 0/1, no memory op -> PCSrc_M follows zero_M, stall_M=0 throughout.
REQ-044 Reset asserted in the second WAIT cycle, then ack pulsed -> dm_req=0 immediately, state IDLE, readData_M=0, ack ignored.
REQ-045 MemRead_M and MemWrite_M both high, writeData_M=0x7 -> write issued, dm_we=1, dm_wdata=0x7.
